// File: rtl/reg_div_n.sv
// Sequential unsigned N-bit divider: enable-gated operand registers feeding a
// restoring shift/subtract engine that retires one quotient bit per clock.
module reg_div_n #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ea,
  input  logic         eb,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         start,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   reg_a_q, reg_a_d;
  logic [N-1:0]   reg_b_q, reg_b_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  logic           accept_c;
  logic [N:0]     rem_sh_c;
  logic [N-1:0]   diff_c;
  logic           ge_c;

  // Operands and start are only honoured when no division is running.
  assign accept_c = (state_q != S_CALC);

  // reg_b cannot change while busy, so it doubles as the working divisor.
  assign rem_sh_c = {rem_q, quo_q[N-1]};
  assign ge_c     = (rem_sh_c >= {1'b0, reg_b_q});
  assign diff_c   = rem_sh_c[N-1:0] - reg_b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      reg_a_q <= '0;
      reg_b_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (reg_b_q == '0) ? S_DONE : S_CALC;
        else       state_d = S_IDLE;
      end
      S_CALC: begin
        if (count_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    busy_d  = (state_d == S_CALC);
    done_d  = (state_d == S_DONE);

    if (accept_c) begin
      if (ea) reg_a_d = a;
      if (eb) reg_b_d = b;
      // start sees the operand values from before this edge.
      if (start) begin
        if (reg_b_q == '0) begin
          q_d  = '1;
          r_d  = reg_a_q;
          dz_d = 1'b1;
        end else begin
          rem_d   = '0;
          quo_d   = reg_a_q;
          count_d = CW'(N - 1);
        end
      end
    end else begin
      rem_d   = ge_c ? diff_c : rem_sh_c[N-1:0];
      quo_d   = {quo_q[N-2:0], ge_c};
      count_d = count_q - CW'(1);
      if (count_q == '0) begin
        q_d  = quo_d;
        r_d  = rem_d;
        dz_d = 1'b0;
      end
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_reg_div_n.sv
// Directed and exhaustive checks of reg_div_n at N=4.
module tb_reg_div_n;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic         ea;
  logic         eb;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         start;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_cmp;
  int n_err;

  reg_div_n #(.N(N)) dut (
    .clk(clk), .reset(reset), .ea(ea), .eb(eb), .a(a), .b(b),
    .start(start), .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] ta, input logic [N-1:0] tb);
    a = ta; b = tb; ea = 1'b1; eb = 1'b1;
    step();
    ea = 1'b0; eb = 1'b0;
  endtask

  // Starts a division on the loaded operands and waits for done; lat counts
  // sampled cycles from the start edge, busy_seen records any busy during it.
  task automatic go(output int lat, output logic busy_seen);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    busy_seen = busy;
    while (!done && lat < 40) begin
      step();
      lat++;
      busy_seen = busy_seen | busy;
    end
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input int eq, input int er, input int edz);
    int   lat;
    logic bs;
    load(ta, tb);
    go(lat, bs);
    chk({tag, "_lat"}, lat, (edz != 0) ? 1 : N + 1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, div_zero, edz);
    chk({tag, "_busy"}, bs, (edz != 0) ? 0 : 1);
    step();
    chk({tag, "_dpulse"}, done, 0);
    chk({tag, "_hold_q"}, q, eq);
  endtask

  initial begin
    int   lat;
    logic bs;
    logic seen;
    n_cmp = 0; n_err = 0;
    reset = 1'b1; ea = 1'b0; eb = 1'b0; a = '0; b = '0; start = 1'b0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    step(); step();
    reset = 1'b0;
    step();

    run_div("t1_13_4", 4'd13, 4'd4, 3, 1, 0);
    run_div("t2_15_1", 4'd15, 4'd1, 15, 0, 0);
    run_div("t2_3_9", 4'd3, 4'd9, 0, 3, 0);
    run_div("t3_7_0", 4'd7, 4'd0, 15, 7, 1);
    run_div("t3_after_dz", 4'd9, 4'd3, 3, 0, 0);

    // Mid-calculation start and ea must be ignored.
    load(4'd14, 4'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    chk("t4_busy", busy, 1);
    a = 4'd1; ea = 1'b1; start = 1'b1;
    step();
    lat++;
    ea = 1'b0; start = 1'b0;
    while (!done && lat < 40) begin step(); lat++; end
    chk("t4_lat", lat, 5);
    chk("t4_q", q, 4);
    chk("t4_r", r, 2);
    step();
    go(lat, bs);
    chk("t4_rega_kept_q", q, 4);
    chk("t4_rega_kept_r", r, 2);

    // Reset mid-division clears everything at once and suppresses done.
    load(4'd12, 4'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    chk("t5_q", q, 0);
    chk("t5_r", r, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_dz", div_zero, 0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); seen = seen | done; end
    chk("t5_no_done", seen, 0);
    // Operand registers were cleared: start alone divides 0 by 0.
    go(lat, bs);
    chk("t5_regs_clr_dz", div_zero, 1);
    chk("t5_regs_clr_r", r, 0);
    step();
    run_div("t5_9_2", 4'd9, 4'd2, 4, 1, 0);

    // Exhaustive non-zero divisors against the bench's own arithmetic.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        load(N'(ia), N'(ib));
        go(lat, bs);
        chk("ex_lat", lat, N + 1);
        chk("ex_q", q, ia / ib);
        chk("ex_r", r, ia % ib);
        chk("ex_inv", (32'(q) * 32'(ib) + 32'(r)), ia);
        chk("ex_rlt", (32'(r) < 32'(ib)) ? 1 : 0, 1);
        step();
        chk("ex_dpulse", done, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
